// File: rtl/regfile_write_arbiter.sv
// Two-requester write-back arbiter for the 8x8 register file, with locked multi-beat ownership.
// Optional macro REGFILE_ARB_RR_EN selects round-robin tie-break; undefined gives fixed A-first priority.
module regfile_write_arbiter #(
  parameter int MAX_LOCK = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_valid,
  input  logic       a_lock,
  input  logic [2:0] a_addr,
  input  logic [7:0] a_data,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic       b_lock,
  input  logic [2:0] b_addr,
  input  logic [7:0] b_data,
  output logic       b_ready,
  output logic       write_enable,
  output logic [2:0] write_reg,
  output logic [7:0] write_data,
  output logic [1:0] owner
);

  // Handshake: a beat transfers on a cycle where x_valid && x_ready; ready never depends on
  // x_lock, and at most one ready is high per cycle.
  localparam logic [3:0] MAX_LOCK_C = 4'(MAX_LOCK);

  // The state encoding equals the owner code, so owner doubles as the FSM debug view.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_t;

  state_t     state;
  logic [3:0] lock_cnt;
  logic       grant_a;
  logic       grant_b;
  logic       beat_acc;
  logic       beat_lock;
`ifdef REGFILE_ARB_RR_EN
  logic       prio_b;
`endif

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state)
      IDLE: begin
        if (a_valid && b_valid) begin
`ifdef REGFILE_ARB_RR_EN
          grant_a = !prio_b;
          grant_b = prio_b;
`else
          grant_a = 1'b1;
`endif
        end else begin
          grant_a = a_valid;
          grant_b = b_valid;
        end
      end
      OWN_A:   grant_a = a_valid;
      OWN_B:   grant_b = b_valid;
      default: ;
    endcase
  end

  // Readies are held low for the whole time reset is asserted.
  assign a_ready   = grant_a && rst_n;
  assign b_ready   = grant_b && rst_n;
  assign beat_acc  = a_ready || b_ready;
  assign beat_lock = a_ready ? a_lock : b_lock;
  assign owner     = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      lock_cnt     <= 4'd0;
      write_enable <= 1'b0;
      write_reg    <= 3'd0;
      write_data   <= 8'd0;
`ifdef REGFILE_ARB_RR_EN
      prio_b       <= 1'b0;
`endif
    end else begin
      write_enable <= beat_acc;
      if (a_ready) begin
        write_reg  <= a_addr;
        write_data <= a_data;
      end else if (b_ready) begin
        write_reg  <= b_addr;
        write_data <= b_data;
      end
`ifdef REGFILE_ARB_RR_EN
      if (a_ready) begin
        prio_b <= 1'b1;
      end else if (b_ready) begin
        prio_b <= 1'b0;
      end
`endif
      case (state)
        IDLE: begin
          if (beat_acc && beat_lock) begin
            state    <= a_ready ? OWN_A : OWN_B;
            lock_cnt <= 4'd1;
          end
        end
        OWN_A, OWN_B: begin
          // Once the counter reaches MAX_LOCK the next owner beat releases regardless of lock.
          if (beat_acc) begin
            if (beat_lock && (lock_cnt < MAX_LOCK_C)) begin
              lock_cnt <= lock_cnt + 4'd1;
            end else begin
              state    <= IDLE;
              lock_cnt <= 4'd0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          lock_cnt <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: per-cycle vector table for readies/owner, plus a write scoreboard
// and a hand-written reset-during-lock sequence.
module tb_regfile_write_arbiter;

`ifdef REGFILE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       a_valid, a_lock, a_ready;
  logic [2:0] a_addr;
  logic [7:0] a_data;
  logic       b_valid, b_lock, b_ready;
  logic [2:0] b_addr;
  logic [7:0] b_data;
  logic       write_enable;
  logic [2:0] write_reg;
  logic [7:0] write_data;
  logic [1:0] owner;

  int total = 0;
  int bad   = 0;

  logic [10:0] exp_q[$];

  typedef struct {
    logic       av;
    logic       al;
    logic [2:0] aa;
    logic [7:0] ad;
    logic       bv;
    logic       bl;
    logic [2:0] ba;
    logic [7:0] bd;
    logic       ear;
    logic       ebr;
    logic [1:0] eo;
  } vec_t;

  vec_t vecs[$];

  regfile_write_arbiter #(.MAX_LOCK(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .a_valid      (a_valid),
    .a_lock       (a_lock),
    .a_addr       (a_addr),
    .a_data       (a_data),
    .a_ready      (a_ready),
    .b_valid      (b_valid),
    .b_lock       (b_lock),
    .b_addr       (b_addr),
    .b_data       (b_data),
    .b_ready      (b_ready),
    .write_enable (write_enable),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .owner        (owner)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // write-port scoreboard: one entry expected per accepted beat, visible one edge later
  task automatic check_write(input logic pending, input string tag);
    logic [10:0] e;
    if (pending) begin
      check({tag, "_we"}, 16'(write_enable), 16'd1);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL %s_sb_underflow: got write with no expected entry", tag);
      end else begin
        e = exp_q.pop_front();
        check({tag, "_reg_data"}, 16'({write_reg, write_data}), 16'(e));
      end
    end else begin
      check({tag, "_we_idle"}, 16'(write_enable), 16'd0);
    end
  endtask

  task automatic drive(input logic av, input logic al, input logic [2:0] aa, input logic [7:0] ad,
                       input logic bv, input logic bl, input logic [2:0] ba, input logic [7:0] bd);
    a_valid = av; a_lock = al; a_addr = aa; a_data = ad;
    b_valid = bv; b_lock = bl; b_addr = ba; b_data = bd;
  endtask

  task automatic add_vec(input logic av, input logic al, input logic [2:0] aa, input logic [7:0] ad,
                         input logic bv, input logic bl, input logic [2:0] ba, input logic [7:0] bd,
                         input logic ear, input logic ebr, input logic [1:0] eo);
    vec_t v;
    v.av = av; v.al = al; v.aa = aa; v.ad = ad;
    v.bv = bv; v.bl = bl; v.ba = ba; v.bd = bd;
    v.ear = ear; v.ebr = ebr; v.eo = eo;
    vecs.push_back(v);
  endtask

  initial begin
    logic pending;
    pending = 1'b0;

    // single A beat, then idle
    add_vec(1, 0, 3'd3, 8'h5A, 0, 0, 3'd0, 8'h00, 1, 0, 2'b00);
    add_vec(0, 0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00, 0, 0, 2'b00);
    add_vec(0, 0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00, 0, 0, 2'b00);
    // lone B beat leaves the pointer favouring A
    add_vec(0, 0, 3'd0, 8'h00, 1, 0, 3'd5, 8'h55, 0, 1, 2'b00);
    // both valid every cycle, no lock
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0)
        add_vec(1, 0, 3'd1, 8'h11, 1, 0, 3'd2, 8'h22, 1, 0, 2'b00);
      else
        add_vec(1, 0, 3'd1, 8'h11, 1, 0, 3'd2, 8'h22, !RR, RR, 2'b00);
    end
    add_vec(0, 0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00, 0, 0, 2'b00);
    // A locks continuously with B waiting: IDLE beat + 4 owned beats, last one forced release
    add_vec(1, 1, 3'd4, 8'h40, 1, 0, 3'd2, 8'h22, 1, 0, 2'b00);
    add_vec(1, 1, 3'd4, 8'h41, 1, 0, 3'd2, 8'h22, 1, 0, 2'b01);
    add_vec(1, 1, 3'd4, 8'h42, 1, 0, 3'd2, 8'h22, 1, 0, 2'b01);
    add_vec(1, 1, 3'd4, 8'h43, 1, 0, 3'd2, 8'h22, 1, 0, 2'b01);
    add_vec(1, 1, 3'd4, 8'h44, 1, 0, 3'd2, 8'h22, 1, 0, 2'b01);
    add_vec(1, 0, 3'd4, 8'h45, 1, 0, 3'd2, 8'h22, !RR, RR, 2'b00);
    // A takes ownership, then goes quiet for 3 cycles while B waits
    add_vec(1, 1, 3'd6, 8'h60, 0, 0, 3'd0, 8'h00, 1, 0, 2'b00);
    for (int i = 0; i < 3; i++)
      add_vec(0, 1, 3'd6, 8'h00, 1, 0, 3'd7, 8'h77, 0, 0, 2'b01);
    add_vec(1, 0, 3'd6, 8'h61, 1, 0, 3'd7, 8'h77, 1, 0, 2'b01);
    // B takes ownership
    add_vec(0, 0, 3'd0, 8'h00, 1, 1, 3'd7, 8'h70, 0, 1, 2'b00);
    add_vec(0, 0, 3'd0, 8'h00, 1, 1, 3'd7, 8'h71, 0, 1, 2'b10);

    // reset with both requesters valid
    rst_n = 1'b0;
    drive(1, 0, 3'd1, 8'hAA, 1, 0, 3'd2, 8'hBB);
    #12;
    check("rst_a_ready", 16'(a_ready), 16'd0);
    check("rst_b_ready", 16'(b_ready), 16'd0);
    check("rst_we", 16'(write_enable), 16'd0);
    check("rst_reg_data", 16'({write_reg, write_data}), 16'd0);
    check("rst_owner", 16'(owner), 16'd0);
    @(negedge clk);
    drive(0, 0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      check_write(pending, $sformatf("v%0d", i));
      drive(vecs[i].av, vecs[i].al, vecs[i].aa, vecs[i].ad,
            vecs[i].bv, vecs[i].bl, vecs[i].ba, vecs[i].bd);
      #1;
      check($sformatf("v%0d_a_ready", i), 16'(a_ready), 16'(vecs[i].ear));
      check($sformatf("v%0d_b_ready", i), 16'(b_ready), 16'(vecs[i].ebr));
      check($sformatf("v%0d_owner", i), 16'(owner), 16'(vecs[i].eo));
      pending = 1'b0;
      if (vecs[i].ear && vecs[i].av) begin
        exp_q.push_back({vecs[i].aa, vecs[i].ad});
        pending = 1'b1;
      end else if (vecs[i].ebr && vecs[i].bv) begin
        exp_q.push_back({vecs[i].ba, vecs[i].bd});
        pending = 1'b1;
      end
    end

    // reset while in OWN_B with write_enable high
    @(negedge clk);
    drive(1, 0, 3'd1, 8'h33, 1, 0, 3'd2, 8'h44);
    check_write(pending, "own_b_last");
    check("own_b_owner", 16'(owner), 16'd2);
    rst_n = 1'b0;
    #1;
    check("async_rst_we", 16'(write_enable), 16'd0);
    check("async_rst_owner", 16'(owner), 16'd0);
    check("async_rst_a_ready", 16'(a_ready), 16'd0);
    check("async_rst_b_ready", 16'(b_ready), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    // pointer back at its reset value: A wins the tie
    check("post_rst_a_ready", 16'(a_ready), 16'd1);
    check("post_rst_b_ready", 16'(b_ready), 16'd0);
    check("post_rst_owner", 16'(owner), 16'd0);
    exp_q.push_back({3'd1, 8'h33});
    @(negedge clk);
    drive(0, 0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00);
    check_write(1'b1, "post_rst");
    @(negedge clk);
    check_write(1'b0, "post_rst_idle");
    check("sb_drained", 16'(exp_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
